// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the debug/loader bridge, the instruction RAM and imem_arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding environment.
interface imem_arbiter_if;
    logic        fetch_req_ip;
    logic [31:0] fetch_addr_ip;
    logic        fetch_gnt_op;
    logic        fetch_rvalid_op;
    logic [31:0] fetch_rdata_op;
    logic        fetch_err_op;

    logic        dbg_req_ip;
    logic        dbg_we_ip;
    logic [31:0] dbg_addr_ip;
    logic [3:0]  dbg_be_ip;
    logic [31:0] dbg_wdata_ip;
    logic        dbg_gnt_op;
    logic        dbg_rvalid_op;
    logic [31:0] dbg_rdata_op;
    logic        dbg_err_op;

    logic        dbg_halt_ip;
    logic        halted_op;

    logic        mem_en_op;
    logic        mem_we_op;
    logic [3:0]  mem_be_op;
    logic [31:0] mem_addr_op;
    logic [31:0] mem_wdata_op;
    logic [31:0] mem_rdata_ip;

    modport slave (
        input  fetch_req_ip, fetch_addr_ip,
        output fetch_gnt_op, fetch_rvalid_op, fetch_rdata_op, fetch_err_op,
        input  dbg_req_ip, dbg_we_ip, dbg_addr_ip, dbg_be_ip, dbg_wdata_ip,
        output dbg_gnt_op, dbg_rvalid_op, dbg_rdata_op, dbg_err_op,
        input  dbg_halt_ip,
        output halted_op,
        output mem_en_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        input  mem_rdata_ip
    );

    modport master (
        output fetch_req_ip, fetch_addr_ip,
        input  fetch_gnt_op, fetch_rvalid_op, fetch_rdata_op, fetch_err_op,
        output dbg_req_ip, dbg_we_ip, dbg_addr_ip, dbg_be_ip, dbg_wdata_ip,
        input  dbg_gnt_op, dbg_rvalid_op, dbg_rdata_op, dbg_err_op,
        output dbg_halt_ip,
        input  halted_op,
        input  mem_en_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        output mem_rdata_ip
    );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: fetch-priority sharing of a 1-cycle-latency RAM with a debug/loader
// port, starvation guard for debug, and a halt FSM that quiesces fetch for runtime reloads.
module imem_arbiter #(
    parameter int SIZE         = 512,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);

    localparam int          CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [31:0] LAST_WORD = 32'(SIZE - 4);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {RUN, HALTING, HALTED} halt_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DBG} owner_t;

    halt_state_t      state, state_next;
    owner_t           resp_owner, resp_owner_next;
    logic             resp_err, resp_err_next;
    logic             resp_we, resp_we_next;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_next;

    logic fetch_legal, dbg_legal;
    logic fetch_gnt, dbg_gnt;

    // Fetch is only grantable in RUN with no halt request, and yields once debug has starved long enough.
    always_comb begin
        fetch_legal = (bus.fetch_addr_ip[1:0] == 2'b00) && (bus.fetch_addr_ip <= LAST_WORD);
        dbg_legal   = (bus.dbg_addr_ip[1:0] == 2'b00) && (bus.dbg_addr_ip <= LAST_WORD);
        fetch_gnt   = rst_n && bus.fetch_req_ip && (state == RUN) && !bus.dbg_halt_ip
                      && !(bus.dbg_req_ip && (starve_cnt == CNT_MAX));
        dbg_gnt     = rst_n && bus.dbg_req_ip && !fetch_gnt;
    end

    assign bus.fetch_gnt_op = fetch_gnt;
    assign bus.dbg_gnt_op   = dbg_gnt;

    // Illegal accesses are granted but never reach the RAM.
    always_comb begin
        bus.mem_en_op    = 1'b0;
        bus.mem_we_op    = 1'b0;
        bus.mem_be_op    = 4'h0;
        bus.mem_addr_op  = 32'h0;
        bus.mem_wdata_op = 32'h0;
        if (fetch_gnt && fetch_legal) begin
            bus.mem_en_op    = 1'b1;
            bus.mem_be_op    = 4'hF;
            bus.mem_addr_op  = bus.fetch_addr_ip;
            bus.mem_wdata_op = bus.dbg_wdata_ip;
        end else if (dbg_gnt && dbg_legal) begin
            bus.mem_en_op    = 1'b1;
            bus.mem_we_op    = bus.dbg_we_ip;
            bus.mem_be_op    = bus.dbg_we_ip ? bus.dbg_be_ip : 4'hF;
            bus.mem_addr_op  = bus.dbg_addr_ip;
            bus.mem_wdata_op = bus.dbg_wdata_ip;
        end
    end

    // Response bookkeeping, starvation counter and halt FSM next-state logic.
    always_comb begin
        resp_owner_next = OWN_NONE;
        resp_err_next   = 1'b0;
        resp_we_next    = 1'b0;
        starve_cnt_next = starve_cnt;
        state_next      = state;

        if (fetch_gnt) begin
            resp_owner_next = OWN_FETCH;
            resp_err_next   = !fetch_legal;
        end else if (dbg_gnt) begin
            resp_owner_next = OWN_DBG;
            resp_err_next   = !dbg_legal;
            resp_we_next    = bus.dbg_we_ip;
        end

        if ((state != RUN) || !bus.dbg_req_ip || dbg_gnt) begin
            starve_cnt_next = '0;
        end else if (fetch_gnt && (starve_cnt != CNT_MAX)) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end

        case (state)
            RUN: begin
                if (bus.dbg_halt_ip) state_next = HALTING;
            end
            HALTING: begin
                if (!bus.dbg_halt_ip)              state_next = RUN;
                else if (resp_owner != OWN_FETCH)  state_next = HALTED;
            end
            HALTED: begin
                if (!bus.dbg_halt_ip) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            resp_owner <= OWN_NONE;
            resp_err   <= 1'b0;
            resp_we    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            resp_owner <= resp_owner_next;
            resp_err   <= resp_err_next;
            resp_we    <= resp_we_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Fetch sees a NOP whenever there is no good instruction, so the core never executes garbage.
    always_comb begin
        bus.fetch_rvalid_op = (resp_owner == OWN_FETCH);
        bus.fetch_err_op    = (resp_owner == OWN_FETCH) && resp_err;
        bus.fetch_rdata_op  = ((resp_owner == OWN_FETCH) && !resp_err) ? bus.mem_rdata_ip : NOP_INSN;
        bus.dbg_rvalid_op   = (resp_owner == OWN_DBG);
        bus.dbg_err_op      = (resp_owner == OWN_DBG) && resp_err;
        bus.dbg_rdata_op    = ((resp_owner == OWN_DBG) && !resp_err && !resp_we) ? bus.mem_rdata_ip : 32'h0;
        bus.halted_op       = (state == HALTED);
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural RAM, a reference memory image and a
// scoreboard queue of expected responses filled at grant time and drained one cycle later.
module tb_imem_arbiter;

    localparam int          SIZE     = 512;
    localparam int          WORDS    = SIZE / 4;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct {
        logic [1:0]  owner;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] ram     [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic        load_en;
    logic [6:0]  load_addr;
    logic [31:0] load_data;
    exp_t        sb_q[$];

    imem_arbiter_if bus();

    imem_arbiter #(.SIZE(SIZE), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency, preloadable from the bench.
    always @(posedge clk) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end else if (bus.mem_en_op) begin
            if (bus.mem_we_op) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be_op[b]) ram[bus.mem_addr_op[8:2]][8*b +: 8] <= bus.mem_wdata_op[8*b +: 8];
            end else begin
                bus.mem_rdata_ip <= ram[bus.mem_addr_op[8:2]];
            end
        end
    end

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'(SIZE - 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input logic exp_halted);
        exp_t e;
        if (sb_q.size() == 0) begin
            e.owner = 2'd0; e.err = 1'b0; e.data = 32'h0;
        end else begin
            e = sb_q.pop_front();
        end
        chk("fetch_rvalid", 32'(bus.fetch_rvalid_op), 32'(e.owner == 2'd1));
        chk("fetch_err",    32'(bus.fetch_err_op),    32'(e.owner == 2'd1 && e.err));
        chk("fetch_rdata",  bus.fetch_rdata_op,       (e.owner == 2'd1) ? e.data : NOP_INSN);
        chk("dbg_rvalid",   32'(bus.dbg_rvalid_op),   32'(e.owner == 2'd2));
        chk("dbg_err",      32'(bus.dbg_err_op),      32'(e.owner == 2'd2 && e.err));
        chk("dbg_rdata",    bus.dbg_rdata_op,         (e.owner == 2'd2) ? e.data : 32'h0);
        chk("halted",       32'(bus.halted_op),       32'(exp_halted));
    endtask

    task automatic applyStimulus(input logic f_req, input logic [31:0] f_addr,
                                 input logic d_req, input logic d_we, input logic [31:0] d_addr,
                                 input logic [3:0] d_be, input logic [31:0] d_wdata,
                                 input logic halt, input logic exp_fgnt, input logic exp_dgnt,
                                 input logic exp_halted);
        exp_t        e;
        logic        exp_en;
        logic [31:0] w;
        bus.fetch_req_ip  = f_req;
        bus.fetch_addr_ip = f_addr;
        bus.dbg_req_ip    = d_req;
        bus.dbg_we_ip     = d_we;
        bus.dbg_addr_ip   = d_addr;
        bus.dbg_be_ip     = d_be;
        bus.dbg_wdata_ip  = d_wdata;
        bus.dbg_halt_ip   = halt;
        #2;
        chk("fetch_gnt", 32'(bus.fetch_gnt_op), 32'(exp_fgnt));
        chk("dbg_gnt",   32'(bus.dbg_gnt_op),   32'(exp_dgnt));
        exp_en = (exp_fgnt && legal(f_addr)) || (exp_dgnt && legal(d_addr));
        chk("mem_en", 32'(bus.mem_en_op), 32'(exp_en));
        e.owner = 2'd0; e.err = 1'b0; e.data = 32'h0;
        if (exp_fgnt) begin
            e.owner = 2'd1;
            e.err   = !legal(f_addr);
            e.data  = e.err ? NOP_INSN : ref_mem[f_addr[8:2]];
            if (!e.err) begin
                chk("mem_addr_f", bus.mem_addr_op, f_addr);
                chk("mem_we_f",   32'(bus.mem_we_op), 32'd0);
            end
        end else if (exp_dgnt) begin
            e.owner = 2'd2;
            e.err   = !legal(d_addr);
            if (!e.err) begin
                chk("mem_addr_d", bus.mem_addr_op, d_addr);
                chk("mem_be_d",   32'(bus.mem_be_op), d_we ? 32'(d_be) : 32'hF);
                if (d_we) begin
                    w = ref_mem[d_addr[8:2]];
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                    ref_mem[d_addr[8:2]] = w;
                end else begin
                    e.data = ref_mem[d_addr[8:2]];
                end
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(exp_halted);
    endtask

    task automatic idleInputs();
        bus.fetch_req_ip = 1'b0; bus.fetch_addr_ip = 32'h0;
        bus.dbg_req_ip = 1'b0; bus.dbg_we_ip = 1'b0; bus.dbg_addr_ip = 32'h0;
        bus.dbg_be_ip = 4'h0; bus.dbg_wdata_ip = 32'h0; bus.dbg_halt_ip = 1'b0;
    endtask

    initial begin
        idleInputs();
        rst_n   = 1'b0;
        load_en = 1'b0;
        load_addr = 7'd0;
        load_data = 32'h0;

        for (int i = 0; i < WORDS; i++) begin
            logic [31:0] v;
            v = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            if (i == 4) v = 32'h0050_0093;
            if (i == 8) v = 32'h1234_5678;
            ref_mem[i] = v;
            load_en    = 1'b1;
            load_addr  = 7'(i);
            load_data  = v;
            @(posedge clk);
            #1;
        end
        load_en = 1'b0;

        // Reset state, with requests present to show grants are held off.
        bus.fetch_req_ip = 1'b1;
        bus.dbg_req_ip   = 1'b1;
        #2;
        chk("rst_fetch_gnt",    32'(bus.fetch_gnt_op), 32'd0);
        chk("rst_dbg_gnt",      32'(bus.dbg_gnt_op), 32'd0);
        chk("rst_mem_en",       32'(bus.mem_en_op), 32'd0);
        chk("rst_fetch_rvalid", 32'(bus.fetch_rvalid_op), 32'd0);
        chk("rst_fetch_rdata",  bus.fetch_rdata_op, NOP_INSN);
        chk("rst_dbg_rdata",    bus.dbg_rdata_op, 32'h0);
        chk("rst_halted",       32'(bus.halted_op), 32'd0);
        idleInputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] fetch read");
        applyStimulus(1, 32'h10, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 32'h0,  0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] contention");
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 32'h10 + 32'(4 * (i % 4)), 1, 0, 32'h40, 4'h0, 32'h0, 0,
                          (i % 5) != 4, (i % 5) == 4, 0);

        $display("[TB] debug write then fetch");
        applyStimulus(0, 32'h0,  1, 1, 32'h20, 4'b0011, 32'hDEAD_BEEF, 0, 0, 1, 0);
        applyStimulus(1, 32'h20, 0, 0, 32'h0,  4'h0,    32'h0,         0, 1, 0, 0);
        applyStimulus(0, 32'h0,  1, 0, 32'h20, 4'h0,    32'h0,         0, 0, 1, 0);
        chk("merged_word", ref_mem[8], 32'h1234_BEEF);

        $display("[TB] errors and boundaries");
        applyStimulus(1, 32'h22,  0, 0, 32'h0,   4'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 32'h0,   1, 0, 32'h200, 4'h0, 32'h0, 0, 0, 1, 0);
        applyStimulus(1, 32'h1FC, 0, 0, 32'h0,   4'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 32'h0,   1, 0, 32'h1FE, 4'h0, 32'h0, 0, 0, 1, 0);

        $display("[TB] halt");
        applyStimulus(1, 32'h10, 0, 0, 32'h0,  4'h0, 32'h0, 1, 0, 0, 0);
        applyStimulus(1, 32'h10, 0, 0, 32'h0,  4'h0, 32'h0, 1, 0, 0, 1);
        applyStimulus(1, 32'h10, 1, 0, 32'h10, 4'h0, 32'h0, 1, 0, 1, 1);
        applyStimulus(1, 32'h10, 0, 0, 32'h0,  4'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 32'h10, 0, 0, 32'h0,  4'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 32'h0,  0, 0, 32'h0,  4'h0, 32'h0, 0, 0, 0, 0);

        $display("[TB] mid-operation reset");
        applyStimulus(1, 32'h10, 1, 0, 32'h40, 4'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(1, 32'h10, 1, 0, 32'h40, 4'h0, 32'h0, 0, 1, 0, 0);
        #2;
        chk("pre_rst_fetch_gnt", 32'(bus.fetch_gnt_op), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("in_rst_fetch_gnt", 32'(bus.fetch_gnt_op), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_fetch_rvalid", 32'(bus.fetch_rvalid_op), 32'd0);
        chk("post_rst_fetch_rdata",  bus.fetch_rdata_op, NOP_INSN);
        chk("post_rst_dbg_rvalid",   32'(bus.dbg_rvalid_op), 32'd0);
        chk("post_rst_halted",       32'(bus.halted_op), 32'd0);
        sb_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 32'h14, 1, 0, 32'h40, 4'h0, 32'h0, 0, i != 4, i == 4, 0);
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
